// File: rtl/lbox_iter.sv
// lbox_iter: iterative forward/inverse Clyde-128 L-box engine with valid/ready handshake.
// Internal state holds byte-bit-reversed words; one or two word-pair cores per cycle.
module lbox_iter #(
   parameter int PAIRS_PER_CYCLE = 2,
   parameter bit SUPPORT_INV     = 1'b1,
   parameter int MAX_REPS_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          sin,
   input  logic                  inv_mode,
   input  logic [MAX_REPS_W-1:0] reps,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          sout,
   output logic                  busy
);
   generate
      if (PAIRS_PER_CYCLE != 1 && PAIRS_PER_CYCLE != 2) begin : g_bad_pairs
         $error("lbox_iter: PAIRS_PER_CYCLE must be 1 or 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [63:0] lbox_fwd(input logic [63:0] p);
      logic [31:0] a, b, c, d;
      a = p[63:32] ^ ror(p[63:32], 12);
      b = p[31:0] ^ ror(p[31:0], 12);
      a = a ^ ror(a, 3);
      b = b ^ ror(b, 3);
      a = a ^ ror(p[63:32], 17);
      b = b ^ ror(p[31:0], 17);
      c = a ^ ror(a, 31);
      d = b ^ ror(b, 31);
      a = a ^ ror(d, 26);
      b = b ^ ror(c, 25);
      a = a ^ ror(c, 15);
      b = b ^ ror(d, 15);
      return {a, b};
   endfunction

   function automatic logic [63:0] lbox_inv(input logic [63:0] p);
      logic [31:0] a, b, c, d;
      a = p[63:32] ^ ror(p[63:32], 25);
      b = p[31:0] ^ ror(p[31:0], 25);
      c = p[63:32] ^ ror(a, 31);
      d = p[31:0] ^ ror(b, 31);
      c = c ^ ror(a, 20);
      d = d ^ ror(b, 20);
      a = c ^ ror(c, 31);
      b = d ^ ror(d, 31);
      c = c ^ ror(b, 26);
      d = d ^ ror(a, 25);
      a = a ^ ror(c, 17);
      b = b ^ ror(d, 17);
      return {ror(a, 16), ror(b, 16)};
   endfunction

   // Reverses bit order inside every byte; self-inverse.
   function automatic logic [127:0] brev(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 128; i++) r[i] = v[(i & ~7) | (7 - (i & 7))];
      return r;
   endfunction

   function automatic logic [63:0] step(input logic inv, input logic [63:0] p);
      return inv ? lbox_inv(p) : lbox_fwd(p);
   endfunction

   state_t                state_q, state_d;
   logic [127:0]          st_q, st_d;
   logic [127:0]          sout_q, sout_d;
   logic [MAX_REPS_W-1:0] cnt_q, cnt_d;
   logic                  pidx_q, pidx_d;
   logic                  inv_q, inv_d;
   logic                  lo_sel, last;
   logic [63:0]           core_a, core_b;

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      sout_d  = sout_q;
      cnt_d   = cnt_q;
      pidx_d  = pidx_q;
      inv_d   = inv_q;
      lo_sel  = (PAIRS_PER_CYCLE == 1) && pidx_q;
      last    = (PAIRS_PER_CYCLE == 2) || pidx_q;
      core_a  = step(inv_q, lo_sel ? st_q[63:0] : st_q[127:64]);
      core_b  = step(inv_q, st_q[63:0]);
      if (state_q == IDLE) begin
         if (in_valid) begin
            st_d    = brev(sin);
            inv_d   = SUPPORT_INV && inv_mode;
            cnt_d   = (reps == '0) ? MAX_REPS_W'(1) : reps;
            pidx_d  = 1'b0;
            state_d = BUSY;
         end
      end else if (state_q == BUSY) begin
         if (PAIRS_PER_CYCLE == 2) st_d = {core_a, core_b};
         else st_d = lo_sel ? {st_q[127:64], core_a} : {core_a, st_q[63:0]};
         pidx_d = (PAIRS_PER_CYCLE == 1) && !pidx_q;
         if (last) begin
            cnt_d = cnt_q - MAX_REPS_W'(1);
            if (cnt_q == MAX_REPS_W'(1)) begin
               state_d = DONE;
               sout_d  = brev(st_d);
            end
         end
      end else if (out_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         st_q    <= '0;
         sout_q  <= '0;
         cnt_q   <= '0;
         pidx_q  <= 1'b0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         sout_q  <= sout_d;
         cnt_q   <= cnt_d;
         pidx_q  <= pidx_d;
         inv_q   <= inv_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sout      = sout_q;
endmodule
